// File: rtl/cpu_mem_ctrl.sv
// Memory and run controller for the 16-bit accumulator CPU: bulk program load,
// CPU bus service while running, then a streamed dump of the data region.
module cpu_mem_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int DATA_BASE = 401
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_start,
    input  logic [ADDR_W-1:0] memory_address,
    input  logic              read_write,
    input  logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] data_in,
    input  logic              start_end,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    input  logic              dump_ready,
    output logic [31:0]       run_cycles,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DATA_BASE);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DUMP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic              run_first_q, run_first_d;
    logic [31:0]       run_cycles_q, run_cycles_d;
    logic [ADDR_W-1:0] dump_ptr_q, dump_ptr_d;
    logic              dump_valid_q, dump_valid_d;
    logic              dump_last_q, dump_last_d;
    logic [DATA_W-1:0] data_in_q;
    logic [DATA_W-1:0] dump_data_q;

    logic load_accept;
    logic cpu_read;
    logic cpu_write;
    logic dump_fetch;
    logic dump_finish;

    assign load_accept = (state_q == S_LOAD) && load_valid;
    assign cpu_read    = (state_q == S_RUN) && !read_write;
    assign cpu_write   = (state_q == S_RUN) && read_write;
    // The output register refills whenever it is empty or being drained, which
    // keeps the stream at one word per cycle under continuous dump_ready.
    assign dump_finish = (state_q == S_DUMP) && dump_valid_q && dump_ready && dump_last_q;
    assign dump_fetch  = (state_q == S_DUMP) && (!dump_valid_q || dump_ready) && !dump_finish;

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        run_first_d  = run_first_q;
        run_cycles_d = run_cycles_q;
        dump_ptr_d   = dump_ptr_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        case (state_q)
            S_LOAD: begin
                if (load_valid) begin
                    load_ptr_d = load_ptr_q + 1'b1;
                    if (load_last || (load_ptr_q == LAST_ADDR)) begin
                        state_d     = S_RUN;
                        run_first_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // start_end is not yet meaningful on the first RUN cycle.
                run_first_d = 1'b0;
                dump_ptr_d  = BASE_ADDR;
                if (run_cycles_q != 32'hFFFF_FFFF) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
                if (!run_first_q && !start_end) begin
                    state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dump_finish) begin
                    state_d      = S_DONE;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                end else if (dump_fetch) begin
                    dump_valid_d = 1'b1;
                    dump_last_d  = (dump_ptr_q == LAST_ADDR);
                    dump_ptr_d   = dump_ptr_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LOAD;
            load_ptr_q   <= '0;
            run_first_q  <= 1'b0;
            run_cycles_q <= '0;
            dump_ptr_q   <= BASE_ADDR;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            data_in_q    <= '0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            run_first_q  <= run_first_d;
            run_cycles_q <= run_cycles_d;
            dump_ptr_q   <= dump_ptr_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            if (cpu_read) begin
                data_in_q <= mem[memory_address];
            end
            if (dump_fetch) begin
                dump_data_q <= mem[dump_ptr_q];
            end else if (dump_finish) begin
                dump_data_q <= '0;
            end
        end
    end

    // Memory contents survive reset; only writes are suppressed while it is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load_accept) begin
                mem[load_ptr_q] <= load_data;
            end else if (cpu_write) begin
                mem[memory_address] <= data_out;
            end
        end
    end

    assign load_ready = (state_q == S_LOAD) && !reset;
    assign cpu_start  = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign data_in    = data_in_q;
    assign dump_valid = dump_valid_q;
    assign dump_data  = dump_data_q;
    assign dump_last  = dump_last_q;
    assign run_cycles = run_cycles_q;

endmodule
